// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART bridge for the CPU data port.
// The RX FIFO buffers bytes coming from the uart receiver, and the TX FIFO
// buffers bytes going to the transmitter. Software sees a status word, an RX
// pop port, a TX push port and a free-running cycle counter.
//
// Handshakes: a byte moves on a uart_* interface only on a cycle where valid
// and ready are both high at the rising edge. valid never depends on ready,
// and ready never depends on valid; both come from registered FIFO state.
module uart_mmio_bridge #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] ADDR_BASE  = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [7:0]  tx_mem [FIFO_DEPTH];

    logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cycle_q, cycle_d;
    logic        tx_drop_q, tx_drop_d;

    logic        sel;
    logic [2:0]  reg_idx;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic        rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
    logic        drop_clr, cyc_clr;
    logic [31:0] status;

    // Address fields and data bits this block never looks at.
    logic        unused_bits;
    assign unused_bits = ^{addr[27:5], addr[1:0], wdata[31:8]};

    // Decode, FIFO flags, handshakes and next-state for every register.
    always_comb begin
        sel      = (addr[31:28] == ADDR_BASE);
        reg_idx  = addr[4:2];

        rx_empty = (rx_wr_q == rx_rd_q);
        rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
        tx_empty = (tx_wr_q == tx_rd_q);
        tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

        // A full FIFO refuses a push even when a pop frees a slot this cycle.
        rx_push     = uart_rx_valid && !rx_full;
        rx_pop      = re && sel && (reg_idx == 3'd1) && !rx_empty;
        tx_push_req = we && sel && (reg_idx == 3'd2);
        tx_push     = tx_push_req && !tx_full;
        tx_pop      = !tx_empty && uart_tx_ready;
        drop_clr    = we && sel && (reg_idx == 3'd0) && wdata[2];
        cyc_clr     = we && sel && (reg_idx == 3'd6);

        status = {29'b0, tx_drop_q, !rx_empty, !tx_full};

        rx_wr_d = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
        tx_wr_d = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;

        tx_drop_d = tx_drop_q;
        if (tx_push_req && tx_full) begin
            tx_drop_d = 1'b1;
        end else if (drop_clr) begin
            tx_drop_d = 1'b0;
        end

        // The clear write takes priority over the increment.
        cycle_d = cyc_clr ? 32'd0 : cycle_q + 32'd1;

        // Loads return pre-edge state; rdata holds when there is no load.
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = 32'd0;
            if (sel) begin
                case (reg_idx)
                    3'd0:    rdata_d = status;
                    3'd1:    rdata_d = rx_empty ? 32'd0 : {24'b0, rx_mem[rx_rd_q[AW-1:0]]};
                    3'd4:    rdata_d = cycle_q;
                    default: rdata_d = 32'd0;
                endcase
            end
        end
    end

    // Pointer, status and counter registers; reset discards buffered bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rdata_q   <= 32'd0;
            cycle_q   <= 32'd0;
            tx_drop_q <= 1'b0;
        end else begin
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rdata_q   <= rdata_d;
            cycle_q   <= cycle_d;
            tx_drop_q <= tx_drop_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate access.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q[AW-1:0]] <= uart_rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wr_q[AW-1:0]] <= wdata[7:0];
        end
    end

    assign rdata         = rdata_q;
    assign uart_rx_ready = !rx_full;
    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q[AW-1:0]];
endmodule
